sc_counter_tick_gen: RTL
========================

Name: sc_counter_tick_gen

Overview:
Multi-channel programmable tick generator for game timing: alien march rate, shot speed, sprite blink. Each channel counts 0..PERIOD at the 50 MHz clock and emits a one-cycle active-low end-of-count pulse. Channels run in periodic or one-shot mode, with per-channel load, enable and clear. Sits between the top-level clock/reset and the game FSMs; replaces the fixed 25-bit free-running counters.

Parameters:
COUNTER_DATAWIDTH_BUS, 25, width W of each channel's count and period registers
CHANNELS, 4, number of independent channels N (1..16)

Ports:
SC_COUNTER_CLOCK_50  input  1  system clock
SC_COUNTER_RESET_InLow  input  1  asynchronous active-low reset
SC_COUNTER_load_InLow  input  N  per-channel load strobe, active low; latches period and mode
SC_COUNTER_period_InBUS  input  N*W  per-channel terminal value; channel i at [i*W +: W]
SC_COUNTER_mode_In  input  N  0 = periodic, 1 = one-shot; sampled only on load
SC_COUNTER_enable_InLow  input  N  count enable, active low
SC_COUNTER_clear_InLow  input  N  synchronous clear, active low
SC_COUNTER_eoc_OutLow  output  N  end-of-count pulse, active low, registered
SC_COUNTER_busy_Out  output  N  1 while the channel is in RUN
SC_COUNTER_count_OutBUS  output  N*W  current count per channel, same packing as the period bus

Behaviour:
- Reset is SC_COUNTER_RESET_InLow, asynchronous, active-low; clock is SC_COUNTER_CLOCK_50. All state updates on its rising edge.
- Reset values: count 0, period register all ones (2^W-1), mode periodic, state IDLE, eoc 1, busy 0.
- Per-channel FSM with states IDLE, RUN and DONE.
  - IDLE: when enable is low, go to RUN with count 0.
  - RUN: count increments by 1 each cycle enable is low. When enable is high, count holds and the state stays RUN.
  - RUN, count == period with enable low: count goes to 0.
    - Periodic: stay in RUN.
    - One-shot: go to DONE.
    - In both modes, eoc is registered low for exactly the next cycle.
  - DONE: count holds at 0 and busy is 0. Enable is ignored. Only clear or load leaves DONE.
- Periodic tick interval is PERIOD+1 enabled cycles. Period 0 gives eoc low on every enabled cycle, i.e. a continuous low level.
- Priority per channel, highest first: clear, load, count.
  - Clear: count 0, state IDLE, eoc 1 next cycle. Period and mode are kept.
  - Load: period and mode latched, count 0, state IDLE. From RUN the channel therefore stops; software re-enables it.
  - Clear and load in the same cycle: clear wins and the new period is not latched.
- eoc is high in every cycle not following a terminal match, including the cycle after clear or load. This holds even if the match and the clear coincide: clear suppresses the pulse.
- Arithmetic is unsigned, W bits; the increment never exceeds the period, so no overflow. A period loaded below the current count cannot occur, because load zeroes the count.
- busy = (state == RUN), combinational from the state register.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Asynchronous reset mid-count forces the reset values immediately.

Optional Feature:
SC_COUNTER_GLOBAL_PAUSE_EN
- Defined: adds input SC_COUNTER_pause_InLow (1 bit). While it is low, every channel in RUN holds its count and generates no eoc, as if enable were high. Clear and load still act.
- Undefined: the port is absent and counting depends only on the per-channel enables.

Decomposition:
- Package sc_counter_pkg holds:
  - state encoding constants: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - mode constants: MODE_PERIODIC = 0, MODE_ONESHOT = 1;
  - default-period helper constant (all ones).
- Sub-module sc_counter_tick_channel implements one channel: FSM, count register, period/mode registers, eoc register. The top instantiates it N times in a generate loop and does the bus slicing and pause gating.

Test Plan:
- W=8, N=2; reset released, then ch0 enable low with no load → period 255, eoc0 low for one cycle every 256 cycles; ch1 stays IDLE with busy1 = 0.
- ch0 load period 4, periodic, then enable low → count sequence 0,1,2,3,4,0,...; eoc0 low the cycle after each count==4, i.e. every 5 cycles; busy0 = 1.
- ch1 load period 3, one-shot, then enable low → exactly one eoc1 pulse, then DONE with busy1 = 0 and count 0. Enable held low for 20 more cycles → no further pulse; load again then enable → one new pulse.
- ch0 running with period 9: enable high for 3 cycles at count 5 → count holds at 5 and the pulse is delayed by 3 cycles. Clear asserted in the same cycle count == 9 → no eoc, count 0, IDLE.
- Load and clear together on ch0 with period_In = 2 → old period kept, IDLE. Then period 0 periodic load and enable → eoc0 low on every enabled cycle.
- Async reset asserted mid-run on both channels → immediate count 0, eoc 1, busy 0, period 255. With SC_COUNTER_GLOBAL_PAUSE_EN defined, pause low for 4 cycles → all counts frozen and no eoc.

Source files
------------

// File: rtl/sc_counter_pkg.sv
// ============================================================================
// Module : sc_counter_pkg
// Brief  : Shared state, mode and default-period definitions for the tick generator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sc_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Sliced down to the channel width; supports widths up to 64 bits.
    localparam logic [63:0] DEFAULT_PERIOD = '1;

endpackage

`default_nettype wire

// File: rtl/sc_counter_tick_channel.sv
// ============================================================================
// Module : sc_counter_tick_channel
// Brief  : One tick channel: IDLE/RUN/DONE FSM, count, period/mode and eoc registers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sc_counter_tick_channel
    import sc_counter_pkg::*;
#(
    parameter int COUNTER_DATAWIDTH_BUS = 25
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_n,
    input  logic [COUNTER_DATAWIDTH_BUS-1:0] period_in,
    input  logic                             mode_in,
    input  logic                             enable_n,
    input  logic                             clear_n,
    output logic                             eoc_n,
    output logic                             busy,
    output logic [COUNTER_DATAWIDTH_BUS-1:0] count
);

    state_t                           state;
    logic [COUNTER_DATAWIDTH_BUS-1:0] period;
    logic                             mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            period <= DEFAULT_PERIOD[COUNTER_DATAWIDTH_BUS-1:0];
            mode   <= MODE_PERIODIC;
            eoc_n  <= 1'b1;
        end else begin
            // The pulse lasts one cycle unless a terminal match re-arms it below.
            eoc_n <= 1'b1;
            if (!clear_n) begin
                state <= IDLE;
                count <= '0;
            end else if (!load_n) begin
                period <= period_in;
                mode   <= mode_in;
                state  <= IDLE;
                count  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!enable_n) begin
                            state <= RUN;
                            count <= '0;
                        end
                    end
                    RUN: begin
                        if (!enable_n) begin
                            if (count == period) begin
                                count <= '0;
                                eoc_n <= 1'b0;
                                if (mode == MODE_ONESHOT) begin
                                    state <= DONE;
                                end
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        count <= '0;
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state == RUN);

endmodule

`default_nettype wire

// File: rtl/sc_counter_tick_gen.sv
// ============================================================================
// Module : sc_counter_tick_gen
// Brief  : N-channel programmable tick generator; optional SC_COUNTER_GLOBAL_PAUSE_EN
//          adds a global active-low pause input.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sc_counter_tick_gen
    import sc_counter_pkg::*;
#(
    parameter int COUNTER_DATAWIDTH_BUS = 25,
    parameter int CHANNELS              = 4
) (
    input  logic                                      SC_COUNTER_CLOCK_50,
    input  logic                                      SC_COUNTER_RESET_InLow,
`ifdef SC_COUNTER_GLOBAL_PAUSE_EN
    input  logic                                      SC_COUNTER_pause_InLow,
`endif
    input  logic [CHANNELS-1:0]                       SC_COUNTER_load_InLow,
    input  logic [CHANNELS*COUNTER_DATAWIDTH_BUS-1:0] SC_COUNTER_period_InBUS,
    input  logic [CHANNELS-1:0]                       SC_COUNTER_mode_In,
    input  logic [CHANNELS-1:0]                       SC_COUNTER_enable_InLow,
    input  logic [CHANNELS-1:0]                       SC_COUNTER_clear_InLow,
    output logic [CHANNELS-1:0]                       SC_COUNTER_eoc_OutLow,
    output logic [CHANNELS-1:0]                       SC_COUNTER_busy_Out,
    output logic [CHANNELS*COUNTER_DATAWIDTH_BUS-1:0] SC_COUNTER_count_OutBUS
);

    logic [CHANNELS-1:0] enable_gated_n;

    // A paused channel behaves exactly as if its own enable were deasserted.
`ifdef SC_COUNTER_GLOBAL_PAUSE_EN
    assign enable_gated_n = SC_COUNTER_enable_InLow | {CHANNELS{~SC_COUNTER_pause_InLow}};
`else
    assign enable_gated_n = SC_COUNTER_enable_InLow;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        sc_counter_tick_channel #(
            .COUNTER_DATAWIDTH_BUS(COUNTER_DATAWIDTH_BUS)
        ) u_channel (
            .clk       (SC_COUNTER_CLOCK_50),
            .rst_n     (SC_COUNTER_RESET_InLow),
            .load_n    (SC_COUNTER_load_InLow[i]),
            .period_in (SC_COUNTER_period_InBUS[i*COUNTER_DATAWIDTH_BUS +: COUNTER_DATAWIDTH_BUS]),
            .mode_in   (SC_COUNTER_mode_In[i]),
            .enable_n  (enable_gated_n[i]),
            .clear_n   (SC_COUNTER_clear_InLow[i]),
            .eoc_n     (SC_COUNTER_eoc_OutLow[i]),
            .busy      (SC_COUNTER_busy_Out[i]),
            .count     (SC_COUNTER_count_OutBUS[i*COUNTER_DATAWIDTH_BUS +: COUNTER_DATAWIDTH_BUS])
        );
    end

endmodule

`default_nettype wire
